// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: read-mode constants and count-width helper for sync_fifo_flags
package sync_fifo_pkg;
  localparam int MODE_STD = 0;
  localparam int MODE_FWFT = 1;
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: clocked-write, combinational-read two-port storage array
module fifo_ram_2p #(
  parameter int datawidth = 8,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [datawidth-1:0]  wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [datawidth-1:0]  rdata
);
  logic [datawidth-1:0] mem [1 << addr_width];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags, sticky errors and std/FWFT read modes
module sync_fifo_flags #(
  parameter int datawidth = 8,
  parameter int addr_width = 3,
  parameter int fwft = 0,
  parameter int af_thresh = 6,
  parameter int ae_thresh = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  winc,
  input  logic [datawidth-1:0]  wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [datawidth-1:0]  rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  import sync_fifo_pkg::*;
  localparam int cw = cnt_w(addr_width);
  localparam int depth = 1 << addr_width;
  localparam bit fw = (fwft == MODE_FWFT);
  logic [cw-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d, ram_cnt;
  logic [datawidth-1:0] rdata_q, rdata_d, ram_rdata;
  logic valid_q, valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr, rd, pop_ram, bypass, we;
  fifo_ram_2p #(.datawidth(datawidth), .addr_width(addr_width)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q[addr_width-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[addr_width-1:0]),
    .rdata (ram_rdata)
  );
  assign wfull = count_q == cw'(depth);
  assign walmost_full = count_q >= cw'(af_thresh);
  assign ralmost_empty = count_q <= cw'(ae_thresh);
  assign rempty = fw ? !valid_q : count_q == '0;
  assign count = count_q;
  assign rdata = rdata_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  always_comb begin
    wr = winc && !wfull && !clr;
    rd = rinc && !rempty && !clr;
    ram_cnt = count_q - cw'(valid_q);
    pop_ram = rd && ram_cnt != '0;
    bypass = fw && wr && (!valid_q || (rd && ram_cnt == '0));
    we = wr && !bypass;
    wptr_d = clr ? '0 : wptr_q + cw'(we);
    rptr_d = clr ? '0 : rptr_q + cw'(pop_ram);
    count_d = clr ? '0 : count_q + cw'(wr) - cw'(rd);
    rdata_d = pop_ram ? ram_rdata : bypass ? wdata : rdata_q;
    valid_d = !clr && fw && (bypass || pop_ram || (valid_q && !rd));
    overflow_d = !clr && (overflow_q || (winc && wfull));
    underflow_d = !clr && (underflow_q || (rinc && rempty));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      overflow_q <= overflow_d;
      underflow_q <= underflow_d;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of standard and FWFT instances of sync_fifo_flags
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic rst;
  logic s_clr, s_winc, s_rinc, s_wfull, s_waf, s_rempty, s_rae, s_ovf, s_unf;
  logic [7:0] s_wdata, s_rdata;
  logic [3:0] s_count;
  logic f_clr, f_winc, f_rinc, f_wfull, f_waf, f_rempty, f_rae, f_ovf, f_unf;
  logic [7:0] f_wdata, f_rdata;
  logic [3:0] f_count;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  sync_fifo_flags u_std (
    .clk(clk), .rst(rst), .clr(s_clr), .winc(s_winc), .wdata(s_wdata), .wfull(s_wfull),
    .walmost_full(s_waf), .rinc(s_rinc), .rdata(s_rdata), .rempty(s_rempty),
    .ralmost_empty(s_rae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );
  sync_fifo_flags #(.fwft(1)) u_fw (
    .clk(clk), .rst(rst), .clr(f_clr), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull),
    .walmost_full(f_waf), .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty),
    .ralmost_empty(f_rae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    {s_clr, s_winc, s_rinc, f_clr, f_winc, f_rinc} = '0;
    s_wdata = '0;
    f_wdata = '0;
    #12;
    chk("rst_rdata", s_rdata, 0);
    chk("rst_rempty", s_rempty, 1);
    chk("rst_wfull", s_wfull, 0);
    chk("rst_rae", s_rae, 1);
    chk("rst_waf", s_waf, 0);
    chk("rst_count", s_count, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_unf", s_unf, 0);
    chk("rst_f_rempty", f_rempty, 1);
    rst = 1'b0;
    tick();
    s_winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_wdata = 8'h11 + 8'(i);
      tick();
      chk($sformatf("t1_count%0d", i), s_count, i + 1);
      chk($sformatf("t1_waf%0d", i), s_waf, (i + 1 >= 6) ? 1 : 0);
      chk($sformatf("t1_wfull%0d", i), s_wfull, (i == 7) ? 1 : 0);
      chk($sformatf("t1_rae%0d", i), s_rae, (i == 0) ? 1 : 0);
      chk($sformatf("t1_rempty%0d", i), s_rempty, 0);
    end
    s_wdata = 8'h99;
    tick();
    s_winc = 1'b0;
    chk("t1_ovf", s_ovf, 1);
    chk("t1_count_full", s_count, 8);
    s_rinc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t2_rdata%0d", i), s_rdata, 8'h11 + i);
      chk($sformatf("t2_count%0d", i), s_count, 7 - i);
      chk($sformatf("t2_rempty%0d", i), s_rempty, (i == 7) ? 1 : 0);
    end
    tick();
    s_rinc = 1'b0;
    chk("t2_unf", s_unf, 1);
    chk("t2_rdata_hold", s_rdata, 8'h18);
    chk("t2_ovf_sticky", s_ovf, 1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("clr_ovf", s_ovf, 0);
    chk("clr_unf", s_unf, 0);
    chk("clr_rdata_kept", s_rdata, 8'h18);
    f_winc = 1'b1;
    f_wdata = 8'hA5;
    tick();
    f_winc = 1'b0;
    chk("t3_rdata", f_rdata, 8'hA5);
    chk("t3_rempty", f_rempty, 0);
    chk("t3_count", f_count, 1);
    f_winc = 1'b1;
    f_rinc = 1'b1;
    f_wdata = 8'h5A;
    tick();
    f_rinc = 1'b0;
    chk("t3_rw_rdata", f_rdata, 8'h5A);
    chk("t3_rw_count", f_count, 1);
    f_wdata = 8'hB1;
    tick();
    f_wdata = 8'hB2;
    tick();
    f_winc = 1'b0;
    chk("t3_count3", f_count, 3);
    chk("t3_head_kept", f_rdata, 8'h5A);
    f_rinc = 1'b1;
    tick();
    chk("t3_pop1", f_rdata, 8'hB1);
    tick();
    chk("t3_pop2", f_rdata, 8'hB2);
    chk("t3_pop2_count", f_count, 1);
    tick();
    chk("t3_empty", f_rempty, 1);
    chk("t3_empty_count", f_count, 0);
    tick();
    f_rinc = 1'b0;
    chk("t3_unf", f_unf, 1);
    f_clr = 1'b1;
    tick();
    f_clr = 1'b0;
    chk("t3_clr_unf", f_unf, 0);
    f_winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_wdata = 8'hC0 + 8'(i);
      tick();
    end
    chk("t3_full", f_wfull, 1);
    f_wdata = 8'hFF;
    tick();
    f_winc = 1'b0;
    chk("t3_ovf", f_ovf, 1);
    chk("t3_full_count", f_count, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_head%0d", i), f_rdata, 8'hC0 + i);
      f_rinc = 1'b1;
      tick();
    end
    f_rinc = 1'b0;
    chk("t3_drained", f_rempty, 1);
    for (int r = 0; r < 5; r++) begin
      s_winc = 1'b1;
      for (int k = 0; k < 3; k++) begin
        s_wdata = 8'(r * 16 + k);
        tick();
      end
      s_winc = 1'b0;
      s_rinc = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk($sformatf("t4_r%0d_k%0d", r, k), s_rdata, r * 16 + k);
      end
      s_rinc = 1'b0;
    end
    chk("t4_count", s_count, 0);
    chk("t4_ovf", s_ovf, 0);
    chk("t4_unf", s_unf, 0);
    s_winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_wdata = 8'h40 + 8'(i);
      tick();
    end
    chk("t5_full", s_wfull, 1);
    s_rinc = 1'b1;
    s_wdata = 8'h77;
    tick();
    s_winc = 1'b0;
    s_rinc = 1'b0;
    chk("t5_count", s_count, 7);
    chk("t5_ovf", s_ovf, 1);
    chk("t5_rdata", s_rdata, 8'h40);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("t5_clr_count", s_count, 0);
    chk("t5_clr_rempty", s_rempty, 1);
    chk("t5_clr_ovf", s_ovf, 0);
    chk("t5_clr_unf", s_unf, 0);
    chk("t5_clr_rdata", s_rdata, 8'h40);
    s_winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_wdata = 8'h60 + 8'(i);
      tick();
    end
    s_winc = 1'b0;
    chk("t6_count5", s_count, 5);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_count", s_count, 0);
    chk("t6_rst_rempty", s_rempty, 1);
    chk("t6_rst_rdata", s_rdata, 0);
    chk("t6_rst_waf", s_waf, 0);
    #1 rst = 1'b0;
    tick();
    s_winc = 1'b1;
    s_wdata = 8'h3C;
    tick();
    s_winc = 1'b0;
    chk("t6_rempty", s_rempty, 0);
    s_rinc = 1'b1;
    tick();
    s_rinc = 1'b0;
    chk("t6_rdata", s_rdata, 8'h3C);
    chk("t6_count0", s_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO: storage plus full control logic. Width and depth are generic, and the read side is selectable between standard (registered read after request) and first-word-fall-through (FWFT). Adds occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow error flags and a synchronous clear. It is the same-clock-domain companion to the async FIFO, for buffering between blocks that share a clock.

Parameters:
datawidth, 8, word width in bits
addr_width, 3, address bits; depth = 1 << addr_width (8)
fwft, 0, 0 = standard read mode, 1 = first-word-fall-through
af_thresh, 6, walmost_full asserted when count >= af_thresh (legal 1..depth)
ae_thresh, 1, ralmost_empty asserted when count <= ae_thresh (legal 0..depth-1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
clr  input  1  synchronous clear (empties FIFO, clears error flags)
winc  input  1  write request
wdata  input  datawidth  write data
wfull  output  1  FIFO holds depth words
walmost_full  output  1  count >= af_thresh
rinc  input  1  read request / pop
rdata  output  datawidth  read data (registered)
rempty  output  1  no word available to read
ralmost_empty  output  1  count <= ae_thresh
count  output  addr_width+1  words held (0..depth)
overflow  output  1  sticky: write requested while full
underflow  output  1  sticky: read requested while empty

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: rdata=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=(af_thresh==0 ? 1 : 0), count=0, overflow=0, underflow=0. Pointers are 0. RAM contents are not reset.
- Status outputs are decoded from registered state only. There is no combinational path from winc/rinc/wdata to any output.
- Write acceptance: winc && !wfull, using the wfull value before the edge. Read acceptance: rinc && !rempty.
- Rejected write: data dropped, overflow set the next edge. Rejected read: rdata holds, underflow set the next edge. Both flags are sticky until rst or clr.
- Pointers: addr_width+1 bits. Address = low addr_width bits; the MSB is the wrap bit. wfull = count==depth.
- count update: +1 on write only, -1 on read only, unchanged when both are accepted. It never exceeds depth and never goes below 0.
- Simultaneous when full: the read is accepted and the write is rejected (overflow set). Simultaneous when empty: the write is accepted and the read is rejected (underflow set).
- Standard mode (fwft=0):
  - rempty = count==0.
  - A read accepted at edge E presents the head word on rdata after E. rdata then holds until the next accepted read.
  - A write at edge E into an empty FIFO clears rempty after E.
- FWFT mode (fwft=1):
  - An output register plus a valid bit hold the head word; count includes that word. rempty = !valid.
  - A write accepted at edge E into an empty FIFO loads the output register directly (bypass). rdata is valid and rempty=0 after E.
  - rinc is a pop: the next word, if any, is loaded at that edge; otherwise valid clears.
  - A pop plus a write at the same edge with one word held: the new word is loaded into the output register, count unchanged.
- clr: priority over winc/rinc. At the edge it zeroes pointers and count, sets rempty=1, clears valid/overflow/underflow, and leaves rdata unchanged.
- rst asserted mid-operation: all state goes to reset values immediately. The first accepted write after deassertion lands in address 0.

Decomposition:
- Package sync_fifo_pkg holds:
  - read-mode constants MODE_STD=0 and MODE_FWFT=1;
  - a function for the pointer-difference count width.
- Sub-module fifo_ram_2p (parameters datawidth, addr_width):
  - write port clocked by clk with write enable;
  - combinational read at raddr.
- The control, flags and output register live in sync_fifo_flags.

Test Plan:
1. Standard mode, defaults: write 0x11..0x18 (8 words) -> wfull=1 and count=8 after the 8th edge; walmost_full=1 from count=6. 9th write 0x99 -> overflow=1, count stays 8.
2. Drain the 8 words with rinc -> rdata 0x11..0x18 in order, one edge after each pop; rempty=1 after the last. An extra rinc -> underflow=1, rdata stays 0x18.
3. FWFT mode: a single write 0xA5 into an empty FIFO -> rdata=0xA5 and rempty=0 after the same edge, count=1. rinc+winc(0x5A) together -> rdata=0x5A, count=1.
4. Wrap-around: 3 writes / 3 reads repeated 5 times (pointers pass 8) -> data order preserved, count returns to 0, flags never set.
5. Simultaneous rinc+winc while full (count=8) -> read accepted, write dropped, count=7, overflow=1. Then clr -> count=0, rempty=1, overflow=0, underflow=0.
6. rst pulse asynchronously mid-burst (count=5) -> outputs go to reset values before the next edge. Post-release write 0x3C then read -> rdata=0x3C.
